host_cmd_master: RTL and testbench

Host-side command initiator for the UART register/ALU command protocol. It takes one high-level request at a time and serialises it into a command byte stream for a UART transmitter. It then collects the response bytes coming back from a UART receiver and returns one assembled response word. It sits in the test/host side of the system, facing the system controller across the serial link.

---
 rtl/host_cmd_pkg.sv | 53 +++++
 rtl/host_cmd_wdog.sv | 33 +++
 rtl/host_cmd_master.sv | 191 +++++++++++++++++++
 tb/tb_host_cmd_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: command byte codes, request encodings, FSM states and
// per-command frame-shape helpers shared by the host command master.
package host_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        REQ_RF_WR   = 2'd0,
        REQ_RF_RD   = 2'd1,
        REQ_ALU_OP  = 2'd2,
        REQ_ALU_NOP = 2'd3
    } req_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_e;

    // Command byte leading each frame.
    function automatic logic [7:0] cmd_code(input req_cmd_e cmd);
        case (cmd)
            REQ_RF_WR:  return CMD_RF_WR;
            REQ_RF_RD:  return CMD_RF_RD;
            REQ_ALU_OP: return CMD_ALU_OP;
            default:    return CMD_ALU_NOP;
        endcase
    endfunction

    // Total frame length in bytes, command byte included.
    function automatic logic [2:0] frame_len(input req_cmd_e cmd);
        case (cmd)
            REQ_RF_WR:  return 3'd3;
            REQ_RF_RD:  return 3'd2;
            REQ_ALU_OP: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

    // Number of response bytes the far end returns.
    function automatic logic [1:0] rsp_count(input req_cmd_e cmd);
        case (cmd)
            REQ_RF_WR:  return 2'd0;
            REQ_RF_RD:  return 2'd1;
            default:    return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_wdog.sv
// host_cmd_wdog: loadable down-counter producing a one-cycle expire strobe
// after TIMEOUT_CYCLES consecutive running, non-loading cycles.
// Only instantiated when HOST_CMD_TIMEOUT_EN is defined.
module host_cmd_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned TO_EFF = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
    localparam int unsigned CW     = (TO_EFF > 1) ? $clog2(TO_EFF + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TO_EFF);

    logic [CW-1:0] cnt_q;

    // Count down while running; any load restarts the full interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expire = run && !load && (cnt_q == CW'(1));

endmodule

// File: rtl/host_cmd_master.sv
// host_cmd_master: serialises one request into a UART command frame, then
// assembles the response bytes into a single response word.
// Optional feature macro: HOST_CMD_TIMEOUT_EN (response timeout watchdog).
module host_cmd_master
    import host_cmd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned RSP_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_cmd,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [3:0]            req_func,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rsp_valid,
    output logic [RSP_WIDTH-1:0]  rsp_data,
    output logic                  rsp_timeout,
    output logic                  rx_unexpected
);

    state_e                state_q, state_d;
    req_cmd_e              cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q, a_q, b_q;
    logic [3:0]            func_q;
    logic [1:0]            byte_idx_q;
    logic [1:0]            rsp_idx_q;
    logic [RSP_WIDTH-1:0]  rsp_data_q;
    logic                  rx_unexp_q;
    logic                  accept;
    logic                  last_byte;
    logic                  last_rsp;
    logic                  no_rsp;
    logic                  expire;

    assign req_ready     = (state_q == ST_IDLE);
    assign accept        = req_valid && req_ready;
    assign tx_valid      = (state_q == ST_SEND);
    assign rsp_valid     = (state_q == ST_DONE);
    assign rsp_data      = rsp_data_q;
    assign rx_unexpected = rx_unexp_q;

    assign last_byte = ({1'b0, byte_idx_q} == (frame_len(cmd_q) - 3'd1));
    assign last_rsp  = (rsp_idx_q == (rsp_count(cmd_q) - 2'd1));
    assign no_rsp    = (rsp_count(cmd_q) == 2'd0);

`ifdef HOST_CMD_TIMEOUT_EN
    logic timed_out_q;

    host_cmd_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk   (CLK),
        .rst_n (RST_n),
        .load  ((state_q != ST_WAIT_RSP) || rx_valid),
        .run   (state_q == ST_WAIT_RSP),
        .expire(expire)
    );

    // Remember that the pending response ended by expiry; cleared per request.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            timed_out_q <= 1'b0;
        end else if (accept) begin
            timed_out_q <= 1'b0;
        end else if ((state_q == ST_WAIT_RSP) && !rx_valid && expire) begin
            timed_out_q <= 1'b1;
        end
    end

    assign rsp_timeout = timed_out_q && (state_q == ST_DONE);
`else
    assign expire      = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a received byte takes priority over expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready && last_byte) state_d = no_rsp ? ST_DONE : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (rx_valid) begin
                    if (last_rsp) state_d = ST_DONE;
                end else if (expire) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame byte selection; driven to zero outside SEND.
    always_comb begin
        tx_data = '0;
        if (state_q == ST_SEND) begin
            case (byte_idx_q)
                2'd0: tx_data = DATA_WIDTH'(cmd_code(cmd_q));
                2'd1: begin
                    case (cmd_q)
                        REQ_RF_WR, REQ_RF_RD: tx_data = DATA_WIDTH'(addr_q);
                        REQ_ALU_OP:           tx_data = a_q;
                        default:              tx_data = DATA_WIDTH'(func_q);
                    endcase
                end
                2'd2: begin
                    case (cmd_q)
                        REQ_RF_WR:  tx_data = data_q;
                        REQ_ALU_OP: tx_data = b_q;
                        default:    tx_data = '0;
                    endcase
                end
                default: tx_data = DATA_WIDTH'(func_q);
            endcase
        end
    end

    // Request capture, byte/response indices, response assembly, stray flag.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cmd_q      <= REQ_RF_WR;
            addr_q     <= '0;
            data_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            func_q     <= '0;
            byte_idx_q <= '0;
            rsp_idx_q  <= '0;
            rsp_data_q <= '0;
            rx_unexp_q <= 1'b0;
        end else begin
            rx_unexp_q <= rx_valid && (state_q != ST_WAIT_RSP);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q      <= req_cmd_e'(req_cmd);
                        addr_q     <= req_addr;
                        data_q     <= req_data;
                        a_q        <= req_a;
                        b_q        <= req_b;
                        func_q     <= req_func;
                        byte_idx_q <= '0;
                        rsp_idx_q  <= '0;
                        rsp_data_q <= '0;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) byte_idx_q <= byte_idx_q + 2'd1;
                end
                ST_WAIT_RSP: begin
                    if (rx_valid) begin
                        if (rsp_idx_q == 2'd0) begin
                            rsp_data_q[DATA_WIDTH-1:0] <= rx_data;
                        end else begin
                            rsp_data_q[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_data;
                        end
                        rsp_idx_q <= rsp_idx_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master: directed table vectors, hand-written corner sequences
// and randomized requests checked against a frame/response model.
`timescale 1ns/1ps
module tb_host_cmd_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned TO = 20;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_cmd = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0, req_a = '0, req_b = '0;
    logic [3:0]    req_func = '0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rsp_valid;
    logic [RW-1:0] rsp_data;
    logic          rsp_timeout;
    logic          rx_unexpected;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 CLK = ~CLK;

    host_cmd_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RSP_WIDTH(RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .req_a(req_a), .req_b(req_b),
        .req_func(req_func),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .rx_unexpected(rx_unexpected)
    );

    typedef struct {
        logic [1:0]      cmd;
        logic [3:0]      addr;
        logic [7:0]      data;
        logic [7:0]      a;
        logic [7:0]      b;
        logic [3:0]      func;
        logic [7:0]      r0;
        logic [7:0]      r1;
        int unsigned     mode;      // 0: tx_ready high, 1: toggling, 2: random
        int unsigned     exp_len;
        logic [3:0][7:0] exp_b;     // byte 0 in the low lane
        int unsigned     exp_nrsp;
        logic [15:0]     exp_rsp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame and response as defined by the protocol, built as a byte list.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [7:0] q[$];
        case (v.cmd)
            2'd0: begin q = '{8'hAA, {4'h0, v.addr}, v.data};          r.exp_nrsp = 0; end
            2'd1: begin q = '{8'hBB, {4'h0, v.addr}};                  r.exp_nrsp = 1; end
            2'd2: begin q = '{8'hCC, v.a, v.b, {4'h0, v.func}};        r.exp_nrsp = 2; end
            default: begin q = '{8'hDD, {4'h0, v.func}};               r.exp_nrsp = 2; end
        endcase
        r.exp_len = q.size();
        r.exp_b = '0;
        foreach (q[i]) r.exp_b[i] = q[i];
        if (r.exp_nrsp == 0)      r.exp_rsp = 16'h0000;
        else if (r.exp_nrsp == 1) r.exp_rsp = {8'h00, v.r0};
        else                      r.exp_rsp = {v.r1, v.r0};
        return r;
    endfunction

    // Issue the request and collect the frame; returns at the negedge after the last transfer.
    task automatic send_frame(input vec_t v);
        int unsigned n = 0;
        int unsigned cyc = 0;
        logic        prev_stall = 1'b0;
        logic [7:0]  prev_data = '0;
        while (!req_ready && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_addr  = v.addr;
        req_data  = v.data;
        req_a     = v.a;
        req_b     = v.b;
        req_func  = v.func;
        @(negedge CLK);
        req_valid = 1'b0;
        req_cmd   = 2'($urandom_range(0, 3));
        req_addr  = 4'($urandom);
        req_data  = 8'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        req_func  = 4'($urandom);
        check("req_ready_busy", req_ready, 0);
        cyc = 0;
        while (n < v.exp_len && cyc < 64) begin
            check("tx_valid_high", tx_valid, 1);
            if (prev_stall) check("tx_stable", tx_data, prev_data);
            case (v.mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 1);
                default: tx_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (tx_ready) begin
                check($sformatf("tx_byte%0d", n), tx_data, v.exp_b[n]);
                n++;
            end
            prev_stall = !tx_ready;
            prev_data  = tx_data;
            cyc++;
            @(negedge CLK);
        end
        check("tx_count", n, v.exp_len);
        if (v.mode == 0) check("tx_cycles", cyc, v.exp_len);
        tx_ready = 1'($urandom_range(0, 1));
        check("tx_valid_low", tx_valid, 0);
    endtask

    // Full transaction: frame, response bytes with random gaps, response checks.
    task automatic run_txn(input vec_t v);
        send_frame(v);
        for (int i = 0; i < int'(v.exp_nrsp); i++) begin
            int unsigned gap = $urandom_range(0, 3);
            repeat (gap) begin
                check("rsp_valid_wait", rsp_valid, 0);
                @(negedge CLK);
            end
            check("rsp_valid_wait", rsp_valid, 0);
            rx_valid = 1'b1;
            rx_data  = (i == 0) ? v.r0 : v.r1;
            @(negedge CLK);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, v.exp_rsp);
        check("rsp_timeout_low", rsp_timeout, 0);
        check("rx_unexpected_quiet", rx_unexpected, 0);
        check("req_ready_done", req_ready, 0);
        @(negedge CLK);
        check("rsp_valid_pulse", rsp_valid, 0);
        check("rsp_hold", rsp_data, v.exp_rsp);
        check("req_ready_after", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        int unsigned cyc;

        vecs[0] = '{cmd:2'd0, addr:4'h5, data:8'h3C, a:8'h00, b:8'h00, func:4'h0, r0:8'h00, r1:8'h00,
                    mode:0, exp_len:3, exp_b:32'h003C05AA, exp_nrsp:0, exp_rsp:16'h0000};
        vecs[1] = '{cmd:2'd1, addr:4'h2, data:8'h00, a:8'h00, b:8'h00, func:4'h0, r0:8'h7E, r1:8'h00,
                    mode:1, exp_len:2, exp_b:32'h000002BB, exp_nrsp:1, exp_rsp:16'h007E};
        vecs[2] = '{cmd:2'd2, addr:4'h0, data:8'h00, a:8'h10, b:8'h20, func:4'h0, r0:8'h30, r1:8'h00,
                    mode:0, exp_len:4, exp_b:32'h002010CC, exp_nrsp:2, exp_rsp:16'h0030};
        vecs[3] = '{cmd:2'd3, addr:4'h0, data:8'h00, a:8'h00, b:8'h00, func:4'h2, r0:8'h00, r1:8'h02,
                    mode:0, exp_len:2, exp_b:32'h000002DD, exp_nrsp:2, exp_rsp:16'h0200};
        vecs[4] = '{cmd:2'd0, addr:4'hF, data:8'hFF, a:8'h00, b:8'h00, func:4'h0, r0:8'h00, r1:8'h00,
                    mode:2, exp_len:3, exp_b:32'h00FF0FAA, exp_nrsp:0, exp_rsp:16'h0000};
        vecs[5] = '{cmd:2'd1, addr:4'h0, data:8'h00, a:8'h00, b:8'h00, func:4'h0, r0:8'hFF, r1:8'h00,
                    mode:1, exp_len:2, exp_b:32'h000000BB, exp_nrsp:1, exp_rsp:16'h00FF};
        vecs[6] = '{cmd:2'd2, addr:4'h0, data:8'h00, a:8'hFF, b:8'h01, func:4'hF, r0:8'hAB, r1:8'hCD,
                    mode:2, exp_len:4, exp_b:32'h0F01FFCC, exp_nrsp:2, exp_rsp:16'hCDAB};

        // Reset values
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rx_unexpected", rx_unexpected, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);

        // Directed table, back to back
        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Stray byte while idle
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        @(negedge CLK);
        rx_valid = 1'b0;
        check("rx_unexpected_pulse", rx_unexpected, 1);
        check("stray_keeps_idle", req_ready, 1);
        check("stray_no_tx", tx_valid, 0);
        @(negedge CLK);
        check("rx_unexpected_clear", rx_unexpected, 0);

        // Reset during the third byte of a write frame
        req_valid = 1'b1;
        req_cmd   = 2'd0;
        req_addr  = 4'h9;
        req_data  = 8'h11;
        tx_ready  = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        check("rst_mid_b0", tx_data, 8'hAA);
        @(negedge CLK);
        check("rst_mid_b1", tx_data, 8'h09);
        @(negedge CLK);
        check("rst_mid_b2_valid", tx_valid, 1);
        #2 RST_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", tx_valid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_rsp_data", rsp_data, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_no_tx", tx_valid, 0);
        end
        run_txn(vecs[2]);

`ifdef HOST_CMD_TIMEOUT_EN
        // Read with no response: expires after TO idle cycles
        v = '{cmd:2'd1, addr:4'h3, data:8'h00, a:8'h00, b:8'h00, func:4'h0, r0:8'h00, r1:8'h00,
              mode:0, exp_len:0, exp_b:'0, exp_nrsp:0, exp_rsp:16'h0};
        v = model(v);
        send_frame(v);
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("to_latency", cyc, TO);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_flag", rsp_timeout, 1);
        check("to_rsp_data", rsp_data, 16'h0000);
        @(negedge CLK);
        check("to_flag_pulse", rsp_timeout, 0);

        // ALU without operands, only the first byte arrives
        v = '{cmd:2'd3, addr:4'h0, data:8'h00, a:8'h00, b:8'h00, func:4'h5, r0:8'h00, r1:8'h00,
              mode:0, exp_len:0, exp_b:'0, exp_nrsp:0, exp_rsp:16'h0};
        v = model(v);
        send_frame(v);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge CLK);
        rx_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("to_part_latency", cyc, TO);
        check("to_part_flag", rsp_timeout, 1);
        check("to_part_rsp_data", rsp_data, 16'h005A);
        @(negedge CLK);
        run_txn(vecs[3]);
`endif

        // Randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            v.cmd  = 2'($urandom_range(0, 3));
            v.addr = 4'($urandom);
            v.data = 8'($urandom);
            v.a    = 8'($urandom);
            v.b    = 8'($urandom);
            v.func = 4'($urandom);
            v.r0   = 8'($urandom);
            v.r1   = 8'($urandom);
            v.mode = $urandom_range(0, 2);
            v = model(v);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
